// File: rtl/result_matrix_writer.sv
// Sink for the complex matrix-multiply result stream: fills a real bank, then an
// imaginary bank, in row-major order, and offers a one-cycle-latency read port.
module result_matrix_writer #(
    parameter int WORD_LEN   = 16,
    parameter int MATRIX_DIM = 4,
    parameter int ADDR_BITS  = 4
) (
    input  logic                 src_clk,
    input  logic                 rst,
    input  logic                 we_final,
    input  logic [WORD_LEN-1:0]  coefficient,
    input  logic                 part_real_done,
    input  logic                 clr,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WORD_LEN-1:0]  rd_real,
    output logic [WORD_LEN-1:0]  rd_imag,
    output logic                 rd_valid,
    output logic [ADDR_BITS:0]   wr_count,
    output logic                 phase_imag,
    output logic                 done,
    output logic                 err
);

    localparam int ELEMS = MATRIX_DIM * MATRIX_DIM;
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] LAST_IDX = (ADDR_BITS + 1)'(ELEMS - 1);
    localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(ELEMS);

    typedef enum logic [1:0] {S_REAL, S_IMAG, S_DONE, S_ERR} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS:0]   wr_count_q, wr_count_d;
    logic                 phase_imag_q, phase_imag_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [WORD_LEN-1:0]  rd_real_q, rd_real_d;
    logic [WORD_LEN-1:0]  rd_imag_q, rd_imag_d;
    logic                 real_we, imag_we;
    logic                 rd_in_range;
    logic [ADDR_BITS-1:0] wr_addr;

    // Banks span the full address space so any rd_addr indexes safely.
    logic [WORD_LEN-1:0]  real_bank [DEPTH];
    logic [WORD_LEN-1:0]  imag_bank [DEPTH];

    assign wr_addr     = wr_count_q[ADDR_BITS-1:0];
    assign rd_in_range = ({1'b0, rd_addr} < FULL_CNT);

    always_comb begin
        state_d      = state_q;
        wr_count_d   = wr_count_q;
        phase_imag_d = phase_imag_q;
        real_we      = 1'b0;
        imag_we      = 1'b0;
        case (state_q)
            S_REAL: begin
                if (we_final) begin
                    if (!part_real_done) begin
                        real_we = 1'b1;
                        if (wr_count_q == LAST_IDX) begin
                            wr_count_d   = '0;
                            state_d      = S_IMAG;
                            phase_imag_d = 1'b1;
                        end else begin
                            wr_count_d = wr_count_q + 1'b1;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_IMAG: begin
                if (we_final) begin
                    if (part_real_done) begin
                        imag_we = 1'b1;
                        if (wr_count_q == LAST_IDX) begin
                            wr_count_d = FULL_CNT;
                            state_d    = S_DONE;
                        end else begin
                            wr_count_d = wr_count_q + 1'b1;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            default: begin
                // Terminal states ignore strobes; clr wins over any strobe.
                if (clr) begin
                    state_d      = S_REAL;
                    wr_count_d   = '0;
                    phase_imag_d = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        rd_valid_d = rd_en;
        rd_real_d  = rd_real_q;
        rd_imag_d  = rd_imag_q;
        if (rd_en) begin
            rd_real_d = rd_in_range ? real_bank[rd_addr] : '0;
            rd_imag_d = rd_in_range ? imag_bank[rd_addr] : '0;
        end
    end

    always_ff @(posedge src_clk) begin
        if (!rst) begin
            state_q      <= S_REAL;
            wr_count_q   <= '0;
            phase_imag_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_real_q    <= '0;
            rd_imag_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_count_q   <= wr_count_d;
            phase_imag_q <= phase_imag_d;
            rd_valid_q   <= rd_valid_d;
            rd_real_q    <= rd_real_d;
            rd_imag_q    <= rd_imag_d;
        end
    end

    // Banks carry no reset; a write in the same cycle as a read lands after the read samples.
    always_ff @(posedge src_clk) begin
        if (rst && real_we) begin
            real_bank[wr_addr] <= coefficient;
        end
        if (rst && imag_we) begin
            imag_bank[wr_addr] <= coefficient;
        end
    end

    assign rd_real    = rd_real_q;
    assign rd_imag    = rd_imag_q;
    assign rd_valid   = rd_valid_q;
    assign wr_count   = wr_count_q;
    assign phase_imag = phase_imag_q;
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);

endmodule

// File: tb/tb_result_matrix_writer.sv
// Randomised scoreboard bench for result_matrix_writer; a behavioural model of
// the two banks predicts read data and status after every cycle.
module tb_result_matrix_writer;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int AB = 4;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          rst, we_final, part_real_done, clr, rd_en;
    logic [W-1:0]  coefficient;
    logic [AB-1:0] rd_addr;
    logic [W-1:0]  rd_real, rd_imag;
    logic          rd_valid, phase_imag, done, err;
    logic [AB:0]   wr_count;

    // Second instance with N=3 exposes addresses beyond the matrix.
    logic          we3, prd3, clr3, rd_en3;
    logic [W-1:0]  coef3;
    logic [AB-1:0] rd_addr3;
    logic [W-1:0]  rd_real3, rd_imag3;
    logic          rd_valid3, phase_imag3, done3, err3;
    logic [AB:0]   wr_count3;

    always #5 clk = ~clk;

    result_matrix_writer #(.WORD_LEN(W), .MATRIX_DIM(N), .ADDR_BITS(AB)) dut (
        .src_clk(clk), .rst(rst), .we_final(we_final), .coefficient(coefficient),
        .part_real_done(part_real_done), .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_real(rd_real), .rd_imag(rd_imag), .rd_valid(rd_valid), .wr_count(wr_count),
        .phase_imag(phase_imag), .done(done), .err(err)
    );

    result_matrix_writer #(.WORD_LEN(W), .MATRIX_DIM(3), .ADDR_BITS(AB)) dut3 (
        .src_clk(clk), .rst(rst), .we_final(we3), .coefficient(coef3),
        .part_real_done(prd3), .clr(clr3), .rd_en(rd_en3), .rd_addr(rd_addr3),
        .rd_real(rd_real3), .rd_imag(rd_imag3), .rd_valid(rd_valid3), .wr_count(wr_count3),
        .phase_imag(phase_imag3), .done(done3), .err(err3)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: stage 0 filling real, 1 filling imag, 2 complete, 3 violated.
    logic [W-1:0] m_real [NN];
    logic [W-1:0] m_imag [NN];
    bit           k_real [NN];
    bit           k_imag [NN];
    int           m_stage;
    int           m_count;
    bit           m_phase;

    typedef struct {
        int           due;
        bit           chk_re;
        bit           chk_im;
        logic [W-1:0] re;
        logic [W-1:0] im;
    } rd_exp_t;
    rd_exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented read response must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                checkOutput("rd_latency", cyc, e.due);
                if (e.chk_re) checkOutput("rd_real", rd_real, e.re);
                if (e.chk_im) checkOutput("rd_imag", rd_imag, e.im);
            end
        end
    end

    task automatic checkState();
        checkOutput("wr_count", wr_count, m_count);
        checkOutput("phase_imag", phase_imag, m_phase);
        checkOutput("done", done, m_stage == 2);
        checkOutput("err", err, m_stage == 3);
    endtask

    task automatic applyStimulus(input bit we, input bit prd, input logic [W-1:0] val,
                                 input bit rd, input logic [AB-1:0] ra, input bit c);
        rd_exp_t e;
        we_final       = we;
        part_real_done = prd;
        coefficient    = val;
        rd_en          = rd;
        rd_addr        = ra;
        clr            = c;
        if (rd) begin
            e.due    = cyc + 1;
            e.chk_re = k_real[ra];
            e.chk_im = k_imag[ra];
            e.re     = m_real[ra];
            e.im     = m_imag[ra];
            sb.push_back(e);
        end
        if (c && m_stage >= 2) begin
            m_stage = 0;
            m_count = 0;
            m_phase = 1'b0;
        end else if (we && m_stage == 0) begin
            if (prd) m_stage = 3;
            else begin
                m_real[m_count] = val;
                k_real[m_count] = 1'b1;
                m_count++;
                if (m_count == NN) begin
                    m_count = 0;
                    m_stage = 1;
                    m_phase = 1'b1;
                end
            end
        end else if (we && m_stage == 1) begin
            if (!prd) m_stage = 3;
            else begin
                m_imag[m_count] = val;
                k_imag[m_count] = 1'b1;
                m_count++;
                if (m_count == NN) m_stage = 2;
            end
        end
        @(posedge clk);
        #1;
        we_final = 1'b0;
        rd_en    = 1'b0;
        clr      = 1'b0;
        checkState();
    endtask

    task automatic doReset();
        rst            = 1'b0;
        we_final       = 1'b1;
        part_real_done = 1'b0;
        coefficient    = 16'hDEAD;
        rd_en          = 1'b1;
        clr            = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        we_final = 1'b0;
        rd_en    = 1'b0;
        clr      = 1'b0;
        m_stage  = 0;
        m_count  = 0;
        m_phase  = 1'b0;
        for (int i = 0; i < NN; i++) begin
            k_real[i] = 1'b0;
            k_imag[i] = 1'b0;
        end
        checkState();
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_real", rd_real, 0);
        checkOutput("rst_rd_imag", rd_imag, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, '0, 0);
    endtask

    task automatic readAll();
        for (int a = 0; a < NN; a++) applyStimulus(0, 0, '0, 1, AB'(a), 0);
    endtask

    task automatic fixedFill(input bit gapped);
        for (int i = 0; i < 2 * NN; i++) begin
            logic [W-1:0] v;
            v = (i < NN) ? W'(i + 1) : W'(-(i - NN + 1));
            applyStimulus(1, i >= NN, v, $urandom_range(0, 1), AB'($urandom_range(0, NN - 1)), 0);
            if (gapped) idle($urandom_range(0, 3));
        end
    endtask

    initial begin
        rst = 1'b1; we_final = 1'b0; part_real_done = 1'b0; coefficient = '0;
        clr = 1'b0; rd_en = 1'b0; rd_addr = '0;
        we3 = 1'b0; prd3 = 1'b0; clr3 = 1'b0; rd_en3 = 1'b0; coef3 = '0; rd_addr3 = '0;
        for (int i = 0; i < NN; i++) begin
            m_real[i] = '0; m_imag[i] = '0; k_real[i] = 1'b0; k_imag[i] = 1'b0;
        end
        m_stage = 0; m_count = 0; m_phase = 1'b0;
        @(posedge clk); #1;
        doReset();
        checkOutput("n3_rst_rd_valid", rd_valid3, 0);

        // Back-to-back fill, then readback including the named addresses
        fixedFill(1'b0);
        applyStimulus(0, 0, '0, 1, 4'd5, 0);
        applyStimulus(0, 0, '0, 1, 4'd15, 0);
        readAll();

        // Gapped refill of the same data
        applyStimulus(0, 0, '0, 0, '0, 1);
        fixedFill(1'b1);
        readAll();

        // Phase violation after three real writes; 0x7FFF must not land anywhere
        applyStimulus(0, 0, '0, 0, '0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, W'(100 + i), 0, '0, 0);
        applyStimulus(1, 1, 16'h7FFF, 0, '0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, i[0], 16'h0BAD, 0, '0, 0);
        applyStimulus(0, 0, '0, 1, 4'd3, 0);
        applyStimulus(0, 0, '0, 0, '0, 1);

        // Reset in the middle of the imaginary fill, then a fresh fill
        for (int i = 0; i < NN + 10; i++) applyStimulus(1, i >= NN, W'($urandom), 0, '0, 0);
        doReset();
        for (int i = 0; i < 2 * NN; i++)
            applyStimulus(1, i >= NN, W'($urandom), $urandom_range(0, 1), AB'($urandom), 0);
        readAll();

        // Read colliding with write #3 returns the previous word, then the new one
        applyStimulus(0, 0, '0, 0, '0, 1);
        applyStimulus(1, 0, 16'h1111, 0, '0, 0);
        applyStimulus(1, 0, 16'h2222, 0, '0, 0);
        applyStimulus(1, 0, 16'h1234, 1, 4'd2, 0);
        applyStimulus(0, 0, '0, 1, 4'd2, 0);

        // Out-of-range address on the 3x3 instance
        rd_en3 = 1'b1; rd_addr3 = 4'd12;
        @(posedge clk); #1;
        rd_en3 = 1'b0;
        checkOutput("n3_oor_valid", rd_valid3, 1);
        checkOutput("n3_oor_real", rd_real3, 0);
        checkOutput("n3_oor_imag", rd_imag3, 0);
        @(posedge clk); #1;
        checkOutput("n3_valid_drop", rd_valid3, 0);

        // Finish the fill, then strobes in S_DONE must change nothing
        for (int i = 3; i < 2 * NN; i++) applyStimulus(1, i >= NN, W'($urandom), 0, '0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, i[0], 16'h5555, 1, AB'(i), 0);
        readAll();
        applyStimulus(1, 0, 16'h5555, 0, '0, 1);
        applyStimulus(0, 0, '0, 1, 4'd0, 0);

        // Random traffic with occasional violations and re-arms
        for (int i = 0; i < 400; i++) begin
            bit we, prd;
            we  = ($urandom_range(0, 3) != 0);
            prd = (m_stage == 1);
            if ($urandom_range(0, 40) == 0) prd = ~prd;
            applyStimulus(we, prd, W'($urandom), $urandom_range(0, 1),
                          AB'($urandom), $urandom_range(0, 7) == 0);
        end
        idle(2);

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_matrix_writer.md
# result_matrix_writer

Downstream sink of the complex matrix-multiply datapath. Captures the coefficient stream produced by the summation stage (`coefficient` qualified by `we_final`) and stores it into two DIM×DIM result banks, real part and imaginary part, in row-major order. Tracks the real/imag phase signalled by the memory manager's `part_real_done` flag and flags protocol violations. Raises `done` when the full complex result matrix is stored. Provides a synchronous read port for the host or testbench.

## Interface
Parameters:
- WORD_LEN, 16, coefficient width in bits (signed two's complement)
- MATRIX_DIM, 4, matrix dimension N; each bank holds N*N words
- ADDR_BITS, 4, element address width; must satisfy 2^ADDR_BITS >= N*N

Ports:
- src_clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  reset, synchronous, active-low
- we_final  in  1  coefficient valid strobe, one cycle per coefficient
- coefficient  in  WORD_LEN  signed coefficient, valid when we_final=1
- part_real_done  in  1  phase of the incoming coefficient: 0 = real part, 1 = imaginary part
- clr  in  1  re-arm pulse; honoured only in S_DONE or S_ERR
- rd_en  in  1  read request
- rd_addr  in  ADDR_BITS  read element address, row*N+col
- rd_real  out  WORD_LEN  real word read from rd_addr
- rd_imag  out  WORD_LEN  imaginary word read from rd_addr
- rd_valid  out  1  rd_real/rd_imag valid, one cycle after rd_en
- wr_count  out  ADDR_BITS+1  coefficients accepted in the current phase
- phase_imag  out  1  0 while filling the real bank, 1 while filling the imaginary bank
- done  out  1  level; full matrix stored
- err  out  1  sticky phase-violation flag

## Operation
- States: S_REAL, S_IMAG, S_DONE, S_ERR. Reset enters S_REAL.
- **S_REAL**
  - A cycle with we_final=1 and part_real_done=0 writes `coefficient` to real_bank[wr_count] and increments wr_count.
  - When the write at wr_count = N*N-1 occurs, wr_count clears to 0 and the state moves to S_IMAG.
- **S_IMAG**
  - Same as S_REAL, but requires part_real_done=1 and writes imag_bank.
  - After the write at N*N-1, the state moves to S_DONE and wr_count holds at N*N.
- **Phase violation**
  - Condition: we_final=1 with the wrong part_real_done for the current state.
  - Response: the sample is dropped (no write), err is set, and the state moves to S_ERR.
  - In S_ERR, all strobes are ignored.
- **S_DONE**: all strobes are ignored; no banks are modified.
- **clr** in S_DONE or S_ERR:
  - Next state S_REAL; wr_count=0, done=0, err=0.
  - Bank contents are retained, not cleared.
  - clr in S_REAL or S_IMAG is ignored.
- **Read port**
  - Independent of state; operates in every state, including mid-fill.
  - rd_en at cycle t drives rd_real/rd_imag/rd_valid registered at edge t+1.
  - Read and write to the same address in the same cycle returns the OLD word (read-before-write).
  - rd_addr >= N*N returns 0 on both outputs, with rd_valid=1.
  - rd_real/rd_imag hold their last value when rd_en=0; rd_valid drops to 0.
- Coefficients are stored bit-exact. No scaling, rounding or saturation.

## Timing
- **Reset** (rst=0 sampled on an edge) sets:
  - state S_REAL, wr_count=0, phase_imag=0, done=0, err=0
  - rd_valid=0, rd_real=0, rd_imag=0
  - Bank contents are undefined after reset; the bench must not rely on them.
- Reset asserted mid-fill aborts the fill; writes resume from address 0 of the real bank.
- **Write**: write latency is 0 cycles.
  - A strobe sampled at edge t is in the bank and reflected in wr_count after edge t.
- **Phase and done timing**
  - phase_imag rises on the same edge as the last real write.
  - done rises on the same edge as the last imag write.
  - err rises on the edge that samples the violating strobe.
- **Read latency**: exactly 1 cycle.
- Back-to-back strobes every cycle are accepted; there is no backpressure.
- Minimum fill time is 2*N*N cycles.
- rst=0 has priority over clr, we_final and rd_en in the same cycle.
- clr has priority over a simultaneous strobe in S_DONE/S_ERR: the strobe is dropped.

## Test plan
1. **Full fill (N=4)**
   - Stimulus: 16 real strobes with values 1..16 (part_real_done=0), then 16 imag strobes with values -1..-16 (part_real_done=1), one per cycle.
   - Required: phase_imag rises after strobe 16, done rises after strobe 32.
   - Readback: rd_addr=5 gives rd_real=6, rd_imag=-6; rd_addr=15 gives 16/-16, each with rd_valid one cycle after rd_en.
2. **Gapped stream**
   - Stimulus: same data as scenario 1, with random 0–3 idle cycles between strobes.
   - Required: identical bank contents; wr_count advances only on strobes.
3. **Phase violation**
   - Stimulus: after 3 real writes, a strobe with part_real_done=1 and value 0x7FFF.
   - Required: err=1, state S_ERR, address 3 of imag_bank unwritten.
   - Follow-on: further strobes are ignored; clr returns to S_REAL with err=0 and wr_count=0.
4. **Reset mid-fill**
   - Stimulus: rst=0 for one cycle after 10 imag writes.
   - Required: wr_count=0, phase_imag=0, done=0. A fresh 32-strobe fill then completes with done=1.
5. **Read/write collision and out-of-range read**
   - Collision: rd_addr=2 with rd_en in the same cycle as real write #3 (value 0x1234) returns the previous word; reading again next cycle returns 0x1234.
   - Out of range: with N=3, ADDR_BITS=4, rd_addr=12 returns 0/0 with rd_valid=1.
6. **Post-done immunity**
   - Stimulus: in S_DONE, 5 extra strobes with value 0x5555.
   - Required: banks unchanged, done stays 1, wr_count stays N*N.
   - Follow-on: clr together with a strobe drops the strobe; wr_count=0 next cycle.
